// File: rtl/burst_mem_responder.sv
// burst_mem_responder: single-port beat memory serving length-counted write and read bursts.
module burst_mem_responder #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      rd_burst_req,
    input  logic                      wr_burst_req,
    input  logic [9:0]                rd_burst_len,
    input  logic [9:0]                wr_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
    output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    output logic                      rd_burst_data_valid,
    output logic                      wr_burst_data_req,
    output logic                      rd_burst_finish,
    output logic                      wr_burst_finish,
    output logic                      busy
);
    typedef enum logic [2:0] {IDLE, WR_BURST, WR_END, RD_BURST, RD_END} state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [9:0]                len_q, len_d;
    logic [9:0]                cnt_q, cnt_d;
    logic                      wr_pend_q, wr_pend_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [DDR_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      wr_req, rd_issue;
    logic                      unused_addr_bits;
    logic [DDR_DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

    assign unused_addr_bits = ^{rd_burst_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                wr_burst_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    // cnt counts issued beats; idx advances on each read issue or delayed write capture
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_req     = (state_q == WR_BURST) && (cnt_q != len_q);
        rd_issue   = (state_q == RD_BURST) && (cnt_q != len_q);
        cnt_d      = cnt_q + 10'(wr_req | rd_issue);
        idx_d      = idx_q + MEM_ADDR_WIDTH'(rd_issue | wr_pend_q);
        wr_pend_d  = wr_req;
        rd_valid_d = rd_issue;
        rd_data_d  = rd_issue ? mem[idx_q] : '0;
        case (state_q)
            IDLE: begin
                if (wr_burst_req) begin
                    state_d = WR_BURST;
                    idx_d   = wr_burst_addr[MEM_ADDR_WIDTH-1:0];
                    len_d   = wr_burst_len;
                    cnt_d   = '0;
                end else if (rd_burst_req) begin
                    state_d = RD_BURST;
                    idx_d   = rd_burst_addr[MEM_ADDR_WIDTH-1:0];
                    len_d   = rd_burst_len;
                    cnt_d   = '0;
                end
            end
            WR_BURST, RD_BURST: if (cnt_q == len_q) state_d = (state_q == WR_BURST) ? WR_END : RD_END;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wr_pend_q  <= wr_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // storage has no reset so contents survive an aborted burst
    always_ff @(posedge mem_clk) begin
        if (rst && wr_pend_q) mem[idx_q] <= wr_burst_data;
    end

    assign busy                = state_q != IDLE;
    assign wr_burst_finish     = state_q == WR_END;
    assign rd_burst_finish     = state_q == RD_END;
    assign wr_burst_data_req   = wr_req;
    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: directed and random bursts checked against an array model of the storage.
module tb_burst_mem_responder;
    logic         mem_clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_burst_req = 1'b0, wr_burst_req = 1'b0;
    logic [9:0]   rd_burst_len = '0, wr_burst_len = '0;
    logic [27:0]  rd_burst_addr = '0, wr_burst_addr = '0;
    logic [127:0] wr_burst_data = '0;
    logic [127:0] rd_burst_data;
    logic         rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish, busy;

    int           vectors = 0, miscompares = 0;
    logic [127:0] model [1024];

    burst_mem_responder dut (
        .mem_clk(mem_clk), .rst(rst),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .rd_burst_data(rd_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish), .busy(busy)
    );

    always #5 mem_clk = ~mem_clk;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit b, input bit wq, input bit wf,
                           input bit v, input logic [127:0] d, input bit rf);
        chk({tag, ".busy"}, 128'(busy), 128'(b));
        chk({tag, ".wr_req"}, 128'(wr_burst_data_req), 128'(wq));
        chk({tag, ".wr_finish"}, 128'(wr_burst_finish), 128'(wf));
        chk({tag, ".rd_valid"}, 128'(rd_burst_data_valid), 128'(v));
        chk({tag, ".rd_data"}, rd_burst_data, d);
        chk({tag, ".rd_finish"}, 128'(rd_burst_finish), 128'(rf));
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after the finish pulse.
    task automatic burst(input bit is_wr, input logic [27:0] addr, input int len,
                         input logic [127:0] d0, input bit other, input bit end_wr, input bit end_rd);
        logic [9:0]   ix;
        logic [127:0] exp_d;
        bit           exp_v;
        wr_burst_req = is_wr;
        rd_burst_req = is_wr ? other : 1'b1;
        if (is_wr) begin
            wr_burst_addr = addr;
            wr_burst_len  = 10'(len);
            rd_burst_addr = 28'($urandom());
            rd_burst_len  = 10'($urandom());
        end else begin
            rd_burst_addr = addr;
            rd_burst_len  = 10'(len);
        end
        step();
        for (int k = 1; k <= len + 2; k++) begin
            exp_v = !is_wr && k >= 2 && k <= len + 1;
            ix    = addr[9:0] + 10'(k - 2);
            exp_d = exp_v ? model[ix] : '0;
            chk_out(is_wr ? "wr" : "rd", 1'b1, is_wr && k <= len, is_wr && k == len + 2,
                    exp_v, exp_d, !is_wr && k == len + 2);
            if (k == len + 2) begin
                wr_burst_req = end_wr;
                rd_burst_req = end_rd;
            end else begin
                wr_burst_req  = 1'($urandom_range(0, 1));
                rd_burst_req  = 1'($urandom_range(0, 1));
                wr_burst_addr = 28'($urandom());
                rd_burst_addr = 28'($urandom());
                wr_burst_len  = 10'($urandom());
                rd_burst_len  = 10'($urandom());
            end
            wr_burst_data = (is_wr && k >= 2 && k <= len + 1) ? d0 + 128'(k - 2) : rnd128();
            step();
        end
        if (is_wr)
            for (int j = 0; j < len; j++) model[addr[9:0] + 10'(j)] = d0 + 128'(j);
        chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        // fill every location so later reads compare against known contents
        burst(1'b1, 28'h0, 1023, rnd128(), 1'b0, 1'b0, 1'b0);
        burst(1'b1, 28'h3FF, 1, rnd128(), 1'b0, 1'b0, 1'b0);
        burst(1'b1, 28'h10, 4, 128'hA0, 1'b0, 1'b0, 1'b0);
        burst(1'b0, 28'h10, 4, '0, 1'b0, 1'b0, 1'b0);
        chk("model_a3", model[10'h13], 128'hA3);
        burst(1'b1, 28'h3FE, 4, rnd128(), 1'b0, 1'b0, 1'b0);
        burst(1'b0, 28'h3FE, 4, '0, 1'b0, 1'b0, 1'b0);
        burst(1'b0, 28'h0, 2, '0, 1'b0, 1'b0, 1'b0);
        burst(1'b0, 28'h55, 0, '0, 1'b0, 1'b0, 1'b0);
        burst(1'b1, 28'h66, 0, rnd128(), 1'b0, 1'b0, 1'b0);
        burst(1'b1, 28'h20, 3, rnd128(), 1'b1, 1'b0, 1'b1);
        burst(1'b0, 28'h20, 3, '0, 1'b0, 1'b0, 1'b0);
        burst(1'b0, 28'h30, 2, '0, 1'b0, 1'b0, 1'b1);
        burst(1'b0, 28'h30, 2, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            chk_out("held_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        // reset lands during the second read beat of an 8-beat burst
        rd_burst_req  = 1'b1;
        rd_burst_addr = 28'h10;
        rd_burst_len  = 10'd8;
        step();
        rd_burst_req = 1'b0;
        chk_out("abort_c1", 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        chk_out("abort_c2", 1'b1, 1'b0, 1'b0, 1'b1, model[10'h10], 1'b0);
        step();
        chk_out("abort_c3", 1'b1, 1'b0, 1'b0, 1'b1, model[10'h11], 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_out("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (10) begin
            step();
            chk_out("abort_after", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        burst(1'b0, 28'h10, 8, '0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            logic [27:0] a;
            a = (n % 5 == 0) ? {18'($urandom()), 10'h3F0 + 10'($urandom_range(0, 15))} : 28'($urandom());
            burst(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 24)), rnd128(),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
